// File: rtl/fp_norm_shifter.sv
// Two-stage FP align/normalize shifter with sticky and exponent range flags.
// Stage 1 resolves the shift count, stage 2 shifts and adjusts the exponent.
module fp_norm_shifter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28,
  parameter int SH_W  = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] mantis,
  input  logic [SH_W-1:0]  shift_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mantis_out,
  output logic             sticky,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);

  localparam int CW = (SH_W > EXP_W) ? SH_W : EXP_W;

  logic             r1_v;
  logic [EXP_W-1:0] r1_exp;
  logic [MAN_W-1:0] r1_man;
  logic [CW-1:0]    r1_sh;
  logic             r1_unf;
  logic             r1_nz;

  logic             r2_v;
  logic [EXP_W-1:0] r2_exp;
  logic [MAN_W-1:0] r2_man;
  logic             r2_st;
  logic             r2_ovf;
  logic             r2_unf;
  logic             r2_zero;

  logic w_s1_adv;
  logic w_s2_adv;

  assign w_s2_adv = !r2_v || out_ready;
  assign w_s1_adv = !r1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  logic [CW-1:0] w_lzc;
  logic [CW-1:0] w_sh_raw;
  logic [CW-1:0] w_sh;
  logic          w_unf;
  logic          w_nz;

  // Highest set bit wins, since it is visited last.
  always_comb begin
    w_lzc = CW'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (mantis[i]) w_lzc = CW'(MAN_W - 1 - i);
    end
  end

  always_comb begin
    w_nz     = (MODE == 2) && (mantis == '0);
    w_sh_raw = (MODE == 2) ? w_lzc : CW'(shift_number);
    w_sh     = w_sh_raw;
    w_unf    = 1'b0;
    if (MODE != 0 && w_sh_raw > CW'(exp)) begin
      w_sh  = CW'(exp);
      w_unf = !w_nz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_exp <= '0;
      r1_man <= '0;
      r1_sh  <= '0;
      r1_unf <= 1'b0;
      r1_nz  <= 1'b0;
    end else begin
      if (w_s1_adv) r1_v <= in_valid;
      if (w_s1_adv && in_valid) begin
        r1_exp <= exp;
        r1_man <= mantis;
        r1_sh  <= w_sh;
        r1_unf <= w_unf;
        r1_nz  <= w_nz;
      end
    end
  end

  logic [2*MAN_W-1:0] w_wide;
  logic [CW:0]        w_sum;
  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W-1:0]   w_man;
  logic               w_st;
  logic               w_ovf;

  always_comb begin
    w_wide = {r1_man, {MAN_W{1'b0}}} >> r1_sh;
    w_sum  = {1'b0, CW'(r1_exp)} + {1'b0, r1_sh};
    w_exp  = '0;
    w_man  = '0;
    w_st   = 1'b0;
    w_ovf  = 1'b0;
    if (MODE == 0) begin
      if (r1_sh >= CW'(MAN_W)) begin
        w_st = |r1_man;
      end else begin
        w_man = w_wide[2*MAN_W-1:MAN_W];
        w_st  = |w_wide[MAN_W-1:0];
      end
      w_ovf = |w_sum[CW:EXP_W];
      w_exp = w_ovf ? '1 : w_sum[EXP_W-1:0];
    end else begin
      if (r1_sh < CW'(MAN_W)) w_man = r1_man << r1_sh;
      w_exp = r1_nz ? '0 : r1_exp - EXP_W'(r1_sh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_exp  <= '0;
      r2_man  <= '0;
      r2_st   <= 1'b0;
      r2_ovf  <= 1'b0;
      r2_unf  <= 1'b0;
      r2_zero <= 1'b0;
    end else begin
      if (w_s2_adv) r2_v <= r1_v;
      if (w_s2_adv && r1_v) begin
        r2_exp  <= w_exp;
        r2_man  <= w_man;
        r2_st   <= w_st;
        r2_ovf  <= w_ovf;
        r2_unf  <= r1_unf;
        r2_zero <= (w_man == '0);
      end
    end
  end

  assign out_valid  = r2_v;
  assign exp_out    = r2_exp;
  assign mantis_out = r2_man;
  assign sticky     = r2_st;
  assign ovf        = r2_ovf;
  assign unf        = r2_unf;
  assign zero       = r2_zero;

endmodule

// File: tb/tb_fp_norm_shifter.sv
// Bench for fp_norm_shifter: one instance per mode sharing stimulus,
// checked against an arithmetic reference model and a result queue.
module tb_fp_norm_shifter;

  typedef struct packed {
    logic [7:0]  e;
    logic [27:0] m;
    logic        st;
    logic        ov;
    logic        un;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  exp_i;
  logic [27:0] man_i;
  logic [7:0]  sh_i;

  logic        ir  [3];
  logic        ovd [3];
  logic [7:0]  eo  [3];
  logic [27:0] mo  [3];
  logic        st  [3];
  logic        ovf [3];
  logic        unf [3];
  logic        zr  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fp_norm_shifter #(.MODE(g)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(ir[g]),
      .exp(exp_i),
      .mantis(man_i),
      .shift_number(sh_i),
      .out_valid(ovd[g]),
      .out_ready(out_ready),
      .exp_out(eo[g]),
      .mantis_out(mo[g]),
      .sticky(st[g]),
      .ovf(ovf[g]),
      .unf(unf[g]),
      .zero(zr[g])
    );
  end

  int   tests = 0;
  int   fails = 0;
  res_t q0[$];
  res_t q1[$];
  res_t q2[$];
  res_t snap[3];
  bit   stall_prev = 0;

  function automatic int lzc(input int m);
    int n = 0;
    int v = m;
    while (v < (1 << 27) && n < 28) begin
      v = v * 2;
      n++;
    end
    return n;
  endfunction

  function automatic res_t model(input int g, input int e,
                                 input int m, input int s);
    res_t   r = '0;
    int     sh;
    longint sum;
    longint wide;
    if (g == 0) begin
      sh = s;
      if (sh >= 28) begin
        r.m  = '0;
        r.st = (m != 0);
      end else begin
        r.m  = 28'(m / (1 << sh));
        r.st = (m % (1 << sh)) != 0;
      end
      sum = e + sh;
      if (sum > 255) begin
        r.e  = 8'hFF;
        r.ov = 1'b1;
      end else begin
        r.e = 8'(sum);
      end
    end else begin
      if (g == 2 && m == 0) begin
        r.z = 1'b1;
        return r;
      end
      sh = (g == 2) ? lzc(m) : s;
      if (sh > e) begin
        sh   = e;
        r.un = 1'b1;
      end
      wide = (sh >= 28) ? 0 : longint'(m) * (longint'(1) << sh);
      r.m  = 28'(wide % (longint'(1) << 28));
      r.e  = 8'(e - sh);
    end
    r.z = (r.m == 0);
    return r;
  endfunction

  function automatic res_t obs(input int g);
    return {eo[g], mo[g], st[g], ovf[g], unf[g], zr[g]};
  endfunction

  task automatic chk(input string tag, input res_t o, input res_t e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic chkb(input string tag, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, o, e);
    end
  endtask

  task automatic push(input int e, input int m, input int s);
    q0.push_back(model(0, e, m, s));
    q1.push_back(model(1, e, m, s));
    q2.push_back(model(2, e, m, s));
  endtask

  task automatic pop_chk(input int g);
    res_t x;
    int   n;
    n = (g == 0) ? q0.size() : (g == 1) ? q1.size() : q2.size();
    tests++;
    assert (n > 0) else begin
      fails++;
      $error("FAIL extra_out[%0d]: got %h expected none", g, obs(g));
    end
    if (n > 0) begin
      if (g == 0) x = q0.pop_front();
      else if (g == 1) x = q1.pop_front();
      else x = q2.pop_front();
      chk($sformatf("result[%0d]", g), obs(g), x);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] e,
                     input logic [27:0] m, input logic [7:0] s,
                     input bit r, output bit acc);
    if (stall_prev) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("hold[%0d]", g), obs(g), snap[g]);
        chkb($sformatf("hold_v[%0d]", g), ovd[g], 1'b1);
      end
    end
    in_valid  = v;
    exp_i     = e;
    man_i     = m;
    sh_i      = s;
    out_ready = r;
    #1;
    if (ovd[0] && out_ready) begin
      for (int g = 0; g < 3; g++) pop_chk(g);
    end
    acc = in_valid && ir[0];
    if (acc) push(e, m, s);
    stall_prev = ovd[0] && !out_ready;
    for (int g = 0; g < 3; g++) snap[g] = obs(g);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, a);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 10; i++) begin
      if (q0.size() != 0 || ovd[0]) cyc(0, 0, 0, 0, 1, a);
    end
    tests++;
    assert (q0.size() == 0) else begin
      fails++;
      $error("FAIL drain: got %0d pending expected 0", q0.size());
    end
  endtask

  // Presents one op then leaves its result on the outputs.
  task automatic solo(input logic [7:0] e, input logic [27:0] m,
                      input logic [7:0] s);
    bit a;
    cyc(1, e, m, s, 1, a);
    chkb("lat_s1", ovd[0], 1'b0);
    cyc(0, 0, 0, 0, 1, a);
    chkb("lat_s2", ovd[0], 1'b1);
  endtask

  initial begin
    bit          a;
    int          idx;
    logic [27:0] m;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_i     = '0;
    man_i     = '0;
    sh_i      = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_out[%0d]", g), obs(g), '0);
      chkb($sformatf("rst_v[%0d]", g), ovd[g], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chkb("rst_in_ready", ir[0], 1'b1);

    solo(8'h10, 28'h00000F3, 8'd4);
    chk("t1_right", obs(0), res_t'{8'h14, 28'h000000F, 1'b1, 1'b0, 1'b0, 1'b0});
    idle(1);
    solo(8'hFE, 28'h0000008, 8'd3);
    chk("t2_ovf", obs(0), res_t'{8'hFF, 28'h0000001, 1'b0, 1'b1, 1'b0, 1'b0});
    idle(1);
    solo(8'h10, 28'h0000123, 8'd40);
    chk("t2_big", obs(0), res_t'{8'h38, 28'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    idle(1);
    solo(8'h20, 28'h0001000, 8'd0);
    chk("t3_norm", obs(2), res_t'{8'h11, 28'h8000000, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(1);
    solo(8'h05, 28'h0001000, 8'd0);
    chk("t3_clamp", obs(2), res_t'{8'h00, 28'h0020000, 1'b0, 1'b0, 1'b1, 1'b0});
    idle(1);
    solo(8'h20, 28'h0, 8'd0);
    chk("t3_zero", obs(2), res_t'{8'h00, 28'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    drain();

    idx = 0;
    for (int c = 0; c < 30 && (idx < 6 || q0.size() != 0); c++) begin
      m = 28'h0100000 >> idx;
      cyc(idx < 6, 8'(8'h30 + idx), m, 8'(idx + 1),
          !(c >= 2 && c <= 4), a);
      if (c == 3) chkb("bp_in_ready", a, 1'b0);
      if (c == 5 || c == 6) chkb("bp_thru", a, 1'b1);
      if (a) idx++;
    end
    drain();

    cyc(1, 8'h40, 28'h0ABCDEF, 8'd5, 0, a);
    cyc(1, 8'h41, 28'h0012345, 8'd6, 0, a);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chkb($sformatf("arst_v[%0d]", g), ovd[g], 1'b0);
      chk($sformatf("arst_out[%0d]", g), obs(g), '0);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    stall_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    solo(8'h22, 28'h0000F00, 8'd8);
    chk("post_rst", obs(0), res_t'{8'h2A, 28'h000000F, 1'b0, 1'b0, 1'b0, 1'b0});
    drain();

    for (int i = 0; i < 400; i++) begin
      m = 28'($urandom()) >> $urandom_range(0, 28);
      cyc($urandom_range(0, 3) != 0, 8'($urandom()), m,
          ($urandom_range(0, 9) == 0) ? 8'($urandom())
                                      : 8'($urandom_range(0, 35)),
          $urandom_range(0, 9) < 7, a);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
